// File: rtl/fifo_feeder_pkg.sv
// Shared types and width helpers for the fifo_feeder row serialiser.
package fifo_feeder_pkg;

  typedef enum logic [1:0] {IDLE, SKEW_ST, SHIFT} feeder_state_t;

  localparam int SKEW_CNT_W = 8;

  function automatic int idx_cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/feeder_cnt.sv
// Loadable down-counter that stops at zero; o_tc flags the terminal count.
module feeder_cnt
  import fifo_feeder_pkg::*;
#(
  parameter int W = SKEW_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == '0);

endmodule

// File: rtl/fifo_feeder.sv
// Accepts one DEPTH-entry row and shifts it into a delay-buffer fifo, top entry first.
// Optional FIFO_FEEDER_STALL_EN adds a stall input that pauses serialisation.
module fifo_feeder
  import fifo_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 8,
  parameter int SKEW  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_vld,
  output logic                  load_rdy,
  input  logic [DEPTH*BITS-1:0] row_data,
  output logic                  shift_en,
  output logic [BITS-1:0]       shift_d,
  output logic                  busy,
  output logic                  done
`ifdef FIFO_FEEDER_STALL_EN
  ,
  input  logic                  stall
`endif
);

  localparam int IDX_W = idx_cnt_w(DEPTH);
  localparam logic [SKEW_CNT_W-1:0] SKEW_LD = (SKEW > 0) ? SKEW_CNT_W'(SKEW - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LD = IDX_W'(DEPTH - 2);

  feeder_state_t r_state, w_state_nxt;
  logic [DEPTH*BITS-1:0] r_row;
  logic                  r_shift_en, r_done;
  logic [BITS-1:0]       r_shift_d;

  logic                  w_shift_en_nxt, w_done_nxt;
  logic [BITS-1:0]       w_shift_d_nxt, w_entry;
  logic                  w_accept, w_stall;
  logic                  w_skew_load, w_skew_en, w_skew_tc;
  logic                  w_idx_load, w_idx_en, w_idx_tc;
  logic [IDX_W-1:0]      w_idx;
  logic [SKEW_CNT_W-1:0] w_skew_cnt_unused;

`ifdef FIFO_FEEDER_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  feeder_cnt #(.W(SKEW_CNT_W)) u_skew_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_skew_load),
    .i_load_val (SKEW_LD),
    .i_en       (w_skew_en),
    .o_cnt      (w_skew_cnt_unused),
    .o_tc       (w_skew_tc)
  );

  // Index counter holds the entry to emit on the next edge; the first entry is emitted on entry to SHIFT.
  feeder_cnt #(.W(IDX_W)) u_idx_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_idx_load),
    .i_load_val (IDX_LD),
    .i_en       (w_idx_en),
    .o_cnt      (w_idx),
    .o_tc       (w_idx_tc)
  );

  assign w_entry = r_row[w_idx*BITS +: BITS];

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_en_nxt = 1'b0;
    w_shift_d_nxt  = '0;
    w_done_nxt     = 1'b0;
    w_accept       = 1'b0;
    w_skew_load    = 1'b0;
    w_skew_en      = 1'b0;
    w_idx_load     = 1'b0;
    w_idx_en       = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_vld) begin
          w_accept = 1'b1;
          if (SKEW > 0) begin
            w_state_nxt = SKEW_ST;
            w_skew_load = 1'b1;
          end else begin
            w_state_nxt    = SHIFT;
            w_shift_en_nxt = 1'b1;
            w_shift_d_nxt  = row_data[(DEPTH-1)*BITS +: BITS];
            w_idx_load     = 1'b1;
          end
        end
      end
      SKEW_ST: begin
        if (!w_stall) begin
          if (w_skew_tc) begin
            w_state_nxt    = SHIFT;
            w_shift_en_nxt = 1'b1;
            w_shift_d_nxt  = r_row[(DEPTH-1)*BITS +: BITS];
            w_idx_load     = 1'b1;
          end else begin
            w_skew_en = 1'b1;
          end
        end
      end
      SHIFT: begin
        // The done cycle is spent in SHIFT so load_rdy rises only after it.
        if (r_done) begin
          w_state_nxt = IDLE;
        end else if (!w_stall) begin
          w_shift_en_nxt = 1'b1;
          w_shift_d_nxt  = w_entry;
          if (w_idx_tc) begin
            w_done_nxt = 1'b1;
          end else begin
            w_idx_en = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_shift_en <= 1'b0;
      r_shift_d  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift_en <= w_shift_en_nxt;
      r_shift_d  <= w_shift_d_nxt;
      r_done     <= w_done_nxt;
      if (w_accept) begin
        r_row <= row_data;
      end
    end
  end

  assign load_rdy = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign shift_en = r_shift_en;
  assign shift_d  = r_shift_d;
  assign done     = r_done;

endmodule

// File: tb/tb_fifo_feeder.sv
// Bench for fifo_feeder: two instances (SKEW=0 and SKEW=3) checked against a per-cycle output schedule.
module tb_fifo_feeder;

  localparam int DEPTH = 8;
  localparam int BITS  = 8;

  typedef struct packed {
    logic       en;
    logic [7:0] d;
    logic       done;
    logic       busy;
    logic       rdy;
  } item_t;

  localparam item_t IDLE_IT = '{en: 1'b0, d: 8'h00, done: 1'b0, busy: 1'b0, rdy: 1'b1};
  localparam item_t WAIT_IT = '{en: 1'b0, d: 8'h00, done: 1'b0, busy: 1'b1, rdy: 1'b0};

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        load_vld = 1'b0;
  logic        stall    = 1'b0;
  logic [63:0] row_data = '0;

  logic       o_rdy  [2];
  logic       o_en   [2];
  logic       o_busy [2];
  logic       o_done [2];
  logic [7:0] o_d    [2];

  int n_checks = 0;
  int n_errors = 0;

  item_t       cur [2] = '{IDLE_IT, IDLE_IT};
  item_t       mq  [2][$];
  logic [63:0] fifo0 = '0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      fifo_feeder #(.DEPTH(DEPTH), .BITS(BITS), .SKEW((g == 0) ? 0 : 3)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_vld (load_vld),
        .load_rdy (o_rdy[g]),
        .row_data (row_data),
        .shift_en (o_en[g]),
        .shift_d  (o_d[g]),
        .busy     (o_busy[g]),
        .done     (o_done[g])
`ifdef FIFO_FEEDER_STALL_EN
        ,
        .stall    (stall)
`endif
      );
    end
  endgenerate

  function automatic int skew_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference: on accept, the next cycles are SKEW waits then DEPTH shifts (top entry first), then one ready gap.
  always @(posedge clk or negedge rst_n) begin
    item_t it;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        cur[i] = IDLE_IT;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cur[i].done) begin
          cur[i] = IDLE_IT;
        end else if (mq[i].size() != 0) begin
          if (stall) cur[i] = WAIT_IT;
          else       cur[i] = mq[i].pop_front();
        end else if (load_vld) begin
          for (int s = 0; s < skew_of(i); s++) mq[i].push_back(WAIT_IT);
          for (int k = 0; k < DEPTH; k++) begin
            it.en   = 1'b1;
            it.d    = row_data[(DEPTH-1-k)*BITS +: BITS];
            it.done = (k == DEPTH - 1);
            it.busy = 1'b1;
            it.rdy  = 1'b0;
            mq[i].push_back(it);
          end
          cur[i] = mq[i].pop_front();
        end else begin
          cur[i] = IDLE_IT;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("inst%0d load_rdy", i), o_rdy[i],  cur[i].rdy);
      chk($sformatf("inst%0d shift_en", i), o_en[i],   cur[i].en);
      chk($sformatf("inst%0d shift_d", i),  o_d[i],    cur[i].d);
      chk($sformatf("inst%0d done", i),     o_done[i], cur[i].done);
      chk($sformatf("inst%0d busy", i),     o_busy[i], cur[i].busy);
    end
  end

  // Delay-buffer fifo of depth 8 fed by instance 0; q is the oldest entry.
  always @(posedge clk) begin
    if (o_en[0]) fifo0 <= {fifo0[55:0], o_d[0]};
  end

  initial begin
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk("reset load_rdy", o_rdy[i], 1);
      chk("reset shift_en", o_en[i], 0);
      chk("reset busy", o_busy[i], 0);
      chk("reset done", o_done[i], 0);
    end
    #1 rst_n = 1'b1;
    step();

    row_data = 64'h0807060504030201;
    load_vld = 1'b1;
    step();
    load_vld = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        chk("row seq shift_en", o_en[0], 1);
        chk("row seq shift_d", o_d[0], 64'(8 - k));
        chk("row seq done", o_done[0], (k == 7) ? 1 : 0);
      end
      if (k == 8) begin
        chk("fifo q after row", fifo0[63:56], 8'h08);
        chk("ready after done", o_rdy[0], 1);
      end
      if (k < 3) begin
        chk("skew idle shift_en", o_en[1], 0);
        chk("skew busy", o_busy[1], 1);
      end
      if (k == 3) begin
        chk("skew first shift_en", o_en[1], 1);
        chk("skew first shift_d", o_d[1], 8'h08);
      end
      step();
    end

    row_data = 64'h1122334455667788;
    load_vld = 1'b1;
    step();
    row_data = 64'hA1B2C3D4E5F60718;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) chk("b2b rdy low", o_rdy[0], 0);
      else       chk("b2b rdy back", o_rdy[0], 1);
      step();
    end
    chk("b2b second shift_en", o_en[0], 1);
    chk("b2b second shift_d", o_d[0], 8'hA1);
    step();
    step();
    step();
    load_vld = 1'b0;
    repeat (25) step();

    row_data = 64'h0F1E2D3C4B5A6978;
    load_vld = 1'b1;
    step();
    load_vld = 1'b0;
    step();
    step();
    step();
    chk("mid-row 4th shift_d", o_d[0], 8'h3C);
    #1 rst_n = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("mid-row reset shift_en", o_en[i], 0);
      chk("mid-row reset busy", o_busy[i], 0);
      chk("mid-row reset load_rdy", o_rdy[i], 1);
      chk("mid-row reset done", o_done[i], 0);
    end
    #1 rst_n = 1'b1;
    step();
    row_data = 64'h8877665544332211;
    load_vld = 1'b1;
    step();
    load_vld = 1'b0;
    repeat (14) step();

    repeat (400) begin
      step();
      load_vld = 1'($urandom_range(0, 1));
      row_data = {$urandom(), $urandom()};
`ifdef FIFO_FEEDER_STALL_EN
      stall = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        step();
        #1 rst_n = 1'b1;
      end
    end
    load_vld = 1'b0;
    stall    = 1'b0;
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
